// File: rtl/seg_scan_scheduler_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
package seg_pkg;

  typedef logic [4:0] dig_t;

  localparam dig_t DIG_BLANK = 5'b0_1111;
  localparam int   DOT_BIT   = 4;

  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_ON    = 2'd1,
    S_OFF   = 2'd2
  } scan_state_t;

  // A digit is a suppression candidate only if both the value and the dot are clear.
  function automatic logic dig_is_zero(input dig_t d);
    return (d[DOT_BIT] == 1'b0) && (d[3:0] == 4'd0);
  endfunction

endpackage

// File: rtl/seg_scan_scheduler_if.sv
// Digit frame inputs and scan outputs of the scheduler, grouped as one bus.
interface seg_scan_scheduler_if;
  import seg_pkg::*;

  logic [39:0] i_digits;
  logic        i_lzs_en;
  logic [2:0]  i_bright;
  logic [2:0]  o_cs_pointer;
  dig_t        o_dig_ctrl;
  logic        o_blank;
  logic        o_frame_done;

  modport master (
    output i_digits, i_lzs_en, i_bright,
    input  o_cs_pointer, o_dig_ctrl, o_blank, o_frame_done
  );

  modport slave (
    input  i_digits, i_lzs_en, i_bright,
    output o_cs_pointer, o_dig_ctrl, o_blank, o_frame_done
  );

endinterface

// File: rtl/seg_scan_scheduler_lzs.sv
// Leading-zero suppression for one 4-digit group; the group's last digit is
// always shown so an all-zero group still reads as a single 0.
module seg_lzs
  import seg_pkg::*;
(
  input  logic        i_en,
  input  logic [19:0] i_grp,
  output logic [19:0] o_grp
);

  logic w_chain;

  // Suppression stays active only while every earlier digit was suppressed.
  always_comb begin
    w_chain = i_en;
    o_grp   = i_grp;
    for (int k = 0; k < 3; k++) begin
      if (w_chain && dig_is_zero(i_grp[5*k +: 5])) begin
        o_grp[5*k +: 5] = DIG_BLANK;
      end else begin
        w_chain = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Digit slot scheduler for the 8-digit display: pointer, blank/on/off timing,
// brightness window and a per-frame snapshot with leading-zero suppression.
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int F_CLK     = 50000000,
  parameter int F_SCAN    = 1000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  seg_scan_scheduler_if.slave   io_seg
);

  localparam int              SLOT_CYC  = F_CLK / F_SCAN;
  localparam int              CW        = $clog2(SLOT_CYC);
  localparam logic [CW-1:0]   SLOT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]     BLANK_W   = (CW+1)'(BLANK_CYC);
  localparam logic [CW+2:0]   ACT_CYC   = (CW+3)'(SLOT_CYC - BLANK_CYC);

  logic            r_run;
  logic [CW-1:0]   r_slot_cnt;
  logic [2:0]      r_ptr;
  scan_state_t     r_state;
  logic [CW-1:0]   r_on_cyc;
  logic [39:0]     r_frame;
  logic            r_lzs_en;
  dig_t            r_dig;
  logic            r_blank;
  logic            r_frame_done;

  logic            w_wrap;
  logic [CW:0]     w_cnt_inc;
  logic [CW-1:0]   w_cnt_next;
  logic [2:0]      w_ptr_next;
  logic [CW+2:0]   w_br_ext;
  logic [CW+2:0]   w_prod;
  logic [CW-1:0]   w_on_raw;
  logic [CW-1:0]   w_on_calc;
  logic [CW-1:0]   w_on_eff;
  logic [CW:0]     w_on_end;
  scan_state_t     w_state_next;
  logic            w_frame_ld;
  logic [39:0]     w_frame_src;
  logic            w_lzs_src;
  logic [39:0]     w_disp;
  dig_t            w_dig_sel;

  // Slot timing: next counter and pointer, and this slot's on-window length.
  always_comb begin
    w_wrap    = (r_slot_cnt == SLOT_LAST);
    w_cnt_inc = {1'b0, r_slot_cnt} + {{CW{1'b0}}, 1'b1};
    w_br_ext  = {{CW{1'b0}}, io_seg.i_bright} + {{(CW+2){1'b0}}, 1'b1};
    w_prod    = ACT_CYC * w_br_ext;
    w_on_raw  = CW'(w_prod >> 3'd3);
    if (w_on_raw == CNT_ZERO) begin
      w_on_calc = CNT_ONE;
    end else begin
      w_on_calc = w_on_raw;
    end
    // Brightness is only live during cycle 0; afterwards the captured value rules.
    if (r_slot_cnt == CNT_ZERO) begin
      w_on_eff = w_on_calc;
    end else begin
      w_on_eff = r_on_cyc;
    end
    w_on_end = BLANK_W + {1'b0, w_on_eff};
    if (!r_run) begin
      w_cnt_next = CNT_ZERO;
      w_ptr_next = 3'd0;
    end else if (w_wrap) begin
      w_cnt_next = CNT_ZERO;
      w_ptr_next = r_ptr + 3'd1;
    end else begin
      w_cnt_next = w_cnt_inc[CW-1:0];
      w_ptr_next = r_ptr;
    end
  end

  // Frame source: the live inputs on the edge that opens slot 0, else the snapshot.
  always_comb begin
    w_frame_ld = i_rst | ~r_run | (w_wrap & (r_ptr == 3'd7));
    if (w_frame_ld) begin
      w_frame_src = io_seg.i_digits;
      w_lzs_src   = io_seg.i_lzs_en;
    end else begin
      w_frame_src = r_frame;
      w_lzs_src   = r_lzs_en;
    end
    w_dig_sel = w_disp[{3'b000, w_ptr_next} * 6'd5 +: 5];
  end

  seg_lzs u_lzs_lo (
    .i_en  (w_lzs_src),
    .i_grp (w_frame_src[19:0]),
    .o_grp (w_disp[19:0])
  );

  seg_lzs u_lzs_hi (
    .i_en  (w_lzs_src),
    .i_grp (w_frame_src[39:20]),
    .o_grp (w_disp[39:20])
  );

  // Next-state logic for the blank / on / off phases of a slot.
  always_comb begin
    w_state_next = r_state;
    if (!r_run) begin
      w_state_next = S_BLANK;
    end else begin
      case (r_state)
        S_BLANK: begin
          if (w_cnt_inc == BLANK_W) begin
            w_state_next = S_ON;
          end else begin
            w_state_next = S_BLANK;
          end
        end
        S_ON: begin
          if (w_wrap) begin
            w_state_next = S_BLANK;
          end else if (w_cnt_inc == w_on_end) begin
            w_state_next = S_OFF;
          end else begin
            w_state_next = S_ON;
          end
        end
        S_OFF: begin
          if (w_wrap) begin
            w_state_next = S_BLANK;
          end else begin
            w_state_next = S_OFF;
          end
        end
        default: w_state_next = S_BLANK;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_BLANK;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counters and registered outputs; r_run marks that slot 0 has been entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_run        <= 1'b0;
      r_slot_cnt   <= CNT_ZERO;
      r_ptr        <= 3'd0;
      r_on_cyc     <= CNT_ONE;
      r_dig        <= DIG_BLANK;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_slot_cnt <= w_cnt_next;
      r_ptr      <= w_ptr_next;
      if (r_run && (r_slot_cnt == CNT_ZERO)) begin
        r_on_cyc <= w_on_calc;
      end
      if (w_cnt_next == CNT_ZERO) begin
        r_dig <= w_dig_sel;
      end
      r_blank      <= (w_state_next != S_ON);
      r_frame_done <= (w_cnt_next == SLOT_LAST) && (w_ptr_next == 3'd7);
    end
  end

  // Frame snapshot, deliberately also loaded while reset is held.
  always_ff @(posedge i_clk) begin
    if (w_frame_ld) begin
      r_frame  <= io_seg.i_digits;
      r_lzs_en <= io_seg.i_lzs_en;
    end
  end

  assign io_seg.o_cs_pointer = r_ptr;
  assign io_seg.o_dig_ctrl   = r_dig;
  assign io_seg.o_blank      = r_blank;
  assign io_seg.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench for seg_scan_scheduler with SLOT_CYC=10, BLANK_CYC=2.
module tb_seg_scan_scheduler;
  import seg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   c        = 0;
  int   cur      = 0;
  int   snap     = 0;
  int   slot_br  = 0;

  logic [39:0] vec_dig [4];
  logic        vec_lzs [4];
  logic [2:0]  vec_br  [4];
  logic [39:0] vec_exp [4];

  seg_scan_scheduler_if sif ();

  seg_scan_scheduler #(
    .F_CLK     (1000),
    .F_SCAN    (100),
    .BLANK_CYC (2)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_seg (sif)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", tag, c, act, exp);
    end
  endtask

  task automatic apply(input int i);
    sif.i_digits = vec_dig[i];
    sif.i_lzs_en = vec_lzs[i];
    sif.i_bright = vec_br[i];
    cur = i;
  endtask

  task automatic check_reset_state();
    check("rst_ptr",   {37'd0, sif.o_cs_pointer}, 40'd0);
    check("rst_blank", {39'd0, sif.o_blank},      40'd1);
    check("rst_dig",   {35'd0, sif.o_dig_ctrl},   40'h0F);
    check("rst_done",  {39'd0, sif.o_frame_done}, 40'd0);
  endtask

  // Each iteration observes cycle c (post-reset numbering), then applies stimulus.
  task automatic run(input int n);
    int cnt;
    int slot;
    logic exp_blank;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cnt  = c % 10;
      slot = (c / 10) % 8;
      if (cnt == 0) slot_br = int'(sif.i_bright);
      if (c % 80 == 0) snap = cur;
      exp_blank = !((cnt >= 2) && (cnt < 3 + slot_br));
      check("ptr",   {37'd0, sif.o_cs_pointer}, 40'(slot));
      check("blank", {39'd0, sif.o_blank},      {39'd0, exp_blank});
      check("done",  {39'd0, sif.o_frame_done}, {39'd0, (c % 80 == 79)});
      check("dig",   {35'd0, sif.o_dig_ctrl},   {35'd0, vec_exp[snap][5*slot +: 5]});
      if (c % 80 == 35) apply((cur + 1) % 4);
      if (c == 264) sif.i_bright = 3'd1;
      c++;
    end
  endtask

  initial begin
    // digits listed d7..d0; expected tables hand-derived
    vec_dig[0] = {5'h00, 5'h00, 5'h00, 5'h00, 5'h02, 5'h01, 5'h00, 5'h00};
    vec_lzs[0] = 1'b1;  vec_br[0] = 3'd3;
    vec_exp[0] = {5'h00, 5'h0F, 5'h0F, 5'h0F, 5'h02, 5'h01, 5'h0F, 5'h0F};
    vec_dig[1] = vec_dig[0];
    vec_lzs[1] = 1'b0;  vec_br[1] = 3'd7;
    vec_exp[1] = {5'h00, 5'h00, 5'h00, 5'h00, 5'h02, 5'h01, 5'h00, 5'h00};
    vec_dig[2] = {5'h05, 5'h00, 5'h0C, 5'h00, 5'h00, 5'h00, 5'h10, 5'h00};
    vec_lzs[2] = 1'b1;  vec_br[2] = 3'd0;
    vec_exp[2] = {5'h05, 5'h00, 5'h0C, 5'h0F, 5'h00, 5'h00, 5'h10, 5'h0F};
    vec_dig[3] = 40'd0;
    vec_lzs[3] = 1'b1;  vec_br[3] = 3'd5;
    vec_exp[3] = {5'h00, 5'h0F, 5'h0F, 5'h0F, 5'h00, 5'h0F, 5'h0F, 5'h0F};

    rst = 1'b1;
    apply(0);
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    c   = 0;
    run(375);

    // reset pulse at slot 5, cycle 4 of the fifth frame
    rst = 1'b1;
    apply(0);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    c   = 0;
    run(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
